// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, lane commands,
// controller FSM states and the captured request payload.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CMD_W  = 3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [CMD_W-1:0] CMD_WORD    = 3'b000;
    localparam logic [CMD_W-1:0] CMD_ZERO    = 3'b001;
    localparam logic [CMD_W-1:0] CMD_HALF_LO = 3'b010;
    localparam logic [CMD_W-1:0] CMD_HALF_HI = 3'b011;
    localparam logic [CMD_W-1:0] CMD_BYTE0   = 3'b100;
    localparam logic [CMD_W-1:0] CMD_BYTE1   = 3'b101;
    localparam logic [CMD_W-1:0] CMD_BYTE2   = 3'b110;
    localparam logic [CMD_W-1:0] CMD_BYTE3   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Copy the right-aligned store data onto every lane the access may hit.
    function automatic logic [DATA_W-1:0] lane_replicate(input logic [DATA_W-1:0] wdata,
                                                         input logic [1:0]        size);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_decoder.sv
// Combinational lane decode: byte enables, extraction command and alignment
// check from access size and the low address bits.
module mem_lane_decoder
    import mem_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       addr_lo,
    output logic [BE_W-1:0]  mem_be_c,
    output logic [CMD_W-1:0] rsp_command_c,
    output logic             misaligned_c
);

    always_comb begin
        mem_be_c      = '0;
        rsp_command_c = CMD_ZERO;
        misaligned_c  = 1'b0;
        case (size)
            SZ_BYTE: begin
                mem_be_c = BE_W'(4'b0001 << addr_lo);
                case (addr_lo)
                    2'd0: rsp_command_c = CMD_BYTE0;
                    2'd1: rsp_command_c = CMD_BYTE1;
                    2'd2: rsp_command_c = CMD_BYTE2;
                    2'd3: rsp_command_c = CMD_BYTE3;
                endcase
            end
            SZ_HALF: begin
                mem_be_c      = addr_lo[1] ? 4'b1100 : 4'b0011;
                rsp_command_c = addr_lo[1] ? CMD_HALF_HI : CMD_HALF_LO;
                misaligned_c  = addr_lo[0];
            end
            SZ_WORD: begin
                mem_be_c      = 4'b1111;
                rsp_command_c = CMD_WORD;
                misaligned_c  = |addr_lo;
            end
            default: misaligned_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// Single-outstanding load/store front end feeding the memory extraction stage.
// Optional bus timeout is enabled with `define MEM_TIMEOUT_EN.
module mem_access_controller
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CMD_W-1:0]  rsp_command,
    output logic              rsp_sign,
    output logic              rsp_misaligned,
    output logic              rsp_error
);

    if (CNT_W < 32 && TIMEOUT_CYCLES >= (32'd1 << CNT_W)) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be below 2**CNT_W");
    end

    state_e            state, state_d;
    req_t              req_q, live, src;
    logic              accept;
    logic [BE_W-1:0]   be_c;
    logic [CMD_W-1:0]  cmd_c;
    logic              mis_c;
    logic              timeout_c;

    logic              req_ready_d, mem_valid_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [BE_W-1:0]   mem_be_d;
    logic [DATA_W-1:0] mem_wdata_d, rsp_data_d;
    logic              rsp_valid_d, rsp_sign_d, rsp_misaligned_d, rsp_error_d;
    logic [CMD_W-1:0]  rsp_command_d;

    assign accept = (state == ST_IDLE) && req_valid;
    assign live   = '{we: req_we, size: req_size, uns: req_unsigned, addr: req_addr, wdata: req_wdata};
    // Decode the live request on acceptance, the captured one afterwards.
    assign src    = accept ? live : req_q;

    mem_lane_decoder u_lane_decoder (
        .size          (src.size),
        .addr_lo       (src.addr[1:0]),
        .mem_be_c      (be_c),
        .rsp_command_c (cmd_c),
        .misaligned_c  (mis_c)
    );

`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    assign busy = (state == ST_ISSUE) || (state == ST_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_d != state && (state_d == ST_ISSUE || state_d == ST_WAIT)) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the edge that would bring the count to TIMEOUT_CYCLES.
    assign timeout_c = busy && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam bit TO_EN = 1'b0;
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            req_q          <= '0;
            req_ready      <= 1'b1;
            mem_valid      <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_command    <= '0;
            rsp_sign       <= 1'b0;
            rsp_misaligned <= 1'b0;
            rsp_error      <= 1'b0;
        end else begin
            state          <= state_d;
            if (accept) req_q <= live;
            req_ready      <= req_ready_d;
            mem_valid      <= mem_valid_d;
            mem_we         <= mem_we_d;
            mem_addr       <= mem_addr_d;
            mem_be         <= mem_be_d;
            mem_wdata      <= mem_wdata_d;
            rsp_valid      <= rsp_valid_d;
            rsp_data       <= rsp_data_d;
            rsp_command    <= rsp_command_d;
            rsp_sign       <= rsp_sign_d;
            rsp_misaligned <= rsp_misaligned_d;
            rsp_error      <= rsp_error_d;
        end
    end

    // Bus handshakes take priority over a timeout hitting on the same edge.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (req_valid) state_d = mis_c ? ST_RESP : ST_ISSUE;
            ST_ISSUE: begin
                if (mem_ready)      state_d = req_q.we ? ST_RESP : ST_WAIT;
                else if (timeout_c) state_d = ST_RESP;
            end
            ST_WAIT:  if (mem_rvalid || timeout_c) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        req_ready_d      = 1'b0;
        mem_valid_d      = 1'b0;
        mem_we_d         = 1'b0;
        mem_addr_d       = '0;
        mem_be_d         = '0;
        mem_wdata_d      = '0;
        rsp_valid_d      = 1'b0;
        rsp_data_d       = '0;
        rsp_command_d    = '0;
        rsp_sign_d       = 1'b0;
        rsp_misaligned_d = 1'b0;
        rsp_error_d      = 1'b0;
        case (state_d)
            ST_IDLE:  req_ready_d = 1'b1;
            ST_ISSUE: begin
                mem_valid_d = 1'b1;
                mem_we_d    = src.we;
                mem_addr_d  = {src.addr[ADDR_W-1:2], 2'b00};
                mem_be_d    = be_c;
                mem_wdata_d = lane_replicate(src.wdata, src.size);
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (state == ST_RESP) begin
                    rsp_data_d       = rsp_data;
                    rsp_command_d    = rsp_command;
                    rsp_sign_d       = rsp_sign;
                    rsp_misaligned_d = rsp_misaligned;
                    rsp_error_d      = rsp_error;
                end else if (state == ST_IDLE) begin
                    rsp_command_d    = CMD_ZERO;
                    rsp_misaligned_d = 1'b1;
                end else if (state == ST_WAIT && mem_rvalid) begin
                    rsp_data_d    = mem_rdata;
                    rsp_command_d = cmd_c;
                    rsp_sign_d    = ~src.uns && (src.size != SZ_WORD);
                end else if (state == ST_ISSUE && mem_ready) begin
                    rsp_command_d = CMD_ZERO;
                end else begin
                    rsp_command_d = CMD_ZERO;
                    rsp_error_d   = TO_EN;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequential load/store front end directly upstream of the memory extraction stage (32-bit word in, 3-bit command in, extracted lane out).
- Accepts one core request at a time and runs the word-aligned bus transaction with valid/ready handshakes.
- Computes byte enables, store-data replication and misalignment.
- Delivers the raw read word plus the matching 3-bit lane command and a sign flag to the extraction stage and its consumer.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting on mem_ready/mem_rvalid before error (used only with the optional feature).
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_valid  out  1  bus request valid.
- mem_ready  in  1  bus accepts request.
- mem_we  out  1  bus write.
- mem_addr  out  32  {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- rsp_valid  out  1  response valid, held until rsp_ready.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  raw captured word, feeds the extraction stage's data input.
- rsp_command  out  3  lane command, feeds the extraction stage's command input.
- rsp_sign  out  1  1 when downstream must sign-extend the extracted lane.
- rsp_misaligned  out  1  request was misaligned or illegal; no bus access made.
- rsp_error  out  1  bus timeout (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; req_ready=1 after reset; all other outputs 0. Reset mid-transaction abandons it. A late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, register all req fields.
  - Misaligned or illegal (size 11; half with addr[0]=1; word with addr[1:0]!=0): go to RESP with rsp_command=001, rsp_data=0, rsp_misaligned=1.
  - Otherwise go to ISSUE.
- ISSUE: mem_valid=1; mem_addr, mem_we, mem_be and mem_wdata held stable until mem_ready. On mem_ready:
  - Store: go to RESP with rsp_command=001, rsp_data=0.
  - Load: go to WAIT.
  - mem_rvalid in ISSUE is ignored.
- WAIT: on mem_rvalid, capture mem_rdata into rsp_data and go to RESP.
- RESP: rsp_valid=1, all rsp_* fields stable. On rsp_ready, go to IDLE.
  - req_ready stays 0 in RESP. A new request can be accepted no earlier than the cycle after the handshake.
- Byte enables:
  - byte: 0001 shifted left by addr[1:0].
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load command:
  - word → 000.
  - half → 010 (addr[1]=0) or 011 (addr[1]=1).
  - byte → 100 + addr[1:0].
- rsp_sign = ~req_unsigned for byte/half loads; 0 for word loads, stores and misaligned requests.
- Minimum load latency with a zero-wait bus: accept at cycle 0, mem_valid at cycle 1, mem_rvalid at cycle 2, rsp_valid at cycle 3.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro: a counter clears on entry to ISSUE and on entry to WAIT, and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_error=1, rsp_command=001, rsp_data=0, and drop mem_valid.
- Without the macro: no counter; rsp_error is constant 0; the controller waits indefinitely.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - lane command constants: CMD_WORD=000, CMD_ZERO=001, CMD_HALF_LO=010, CMD_HALF_HI=011, CMD_BYTE0..CMD_BYTE3=100..111.
  - the FSM state enum.
- One natural sub-module: mem_lane_decoder. Purely combinational; inputs size and addr[1:0]; outputs mem_be, rsp_command and misaligned.

Test Plan:
- Load word at 0x100, bus returns 0xDEADBEEF with zero wait → rsp_valid at cycle 3, rsp_data=0xDEADBEEF, rsp_command=000, rsp_sign=0.
- Signed byte load at 0x103 → mem_addr=0x100, rsp_command=111, rsp_sign=1; unsigned half at 0x102 → rsp_command=011, rsp_sign=0.
- Store byte 0xA5 at 0x201 → mem_be=0010, mem_wdata=0xA5A5A5A5, mem_we=1; mem_ready held low 3 cycles → outputs stable throughout, then rsp_command=001.
- Half load at 0x101 → no mem_valid ever asserted, rsp_misaligned=1, rsp_command=001.
- rsp_ready low 5 cycles, req_valid high → req_ready stays 0 and response stays stable; rst_n low during WAIT → IDLE next cycle, later mem_rvalid ignored.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mem_rvalid never asserted → rsp_error=1 after 4 WAIT cycles; without the macro, still in WAIT after 100 cycles.
